// File: rtl/pasta_xof_sched.sv
// Job sequencer for the SHAKE128 rejection sampler: resets and runs the XOF per block,
// captures completed (vec1, vec2) pairs into a 2-deep buffer and streams them to the affine layer.
module pasta_xof_sched #(
    parameter int BITLEN = 17,
    parameter int S      = 32,
    parameter int PAIRS  = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [63:0]                               nonce,
    input  logic [63:0]                               block_counter,
    output logic                                      busy,
    output logic                                      xof_rst,
    output logic                                      xof_run,
    output logic [63:0]                               xof_nonce,
    output logic [63:0]                               xof_block_counter,
    input  logic [BITLEN*S-1:0]                       xof_vec1,
    input  logic [BITLEN*S-1:0]                       xof_vec2,
    input  logic                                      xof_flag,
    output logic                                      pair_valid,
    input  logic                                      pair_ready,
    output logic [BITLEN*S-1:0]                       pair_vec1,
    output logic [BITLEN*S-1:0]                       pair_vec2,
    output logic [((PAIRS > 1) ? $clog2(PAIRS) : 1)-1:0] pair_idx,
    output logic                                      job_done,
    output logic                                      overflow
);
    localparam int VW = BITLEN * S;
    localparam int IW = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    typedef enum logic [1:0] {IDLE, XRST, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [VW-1:0] v1;
        logic [VW-1:0] v2;
        logic [IW-1:0] idx;
    } entry_t;

    state_t        state_q, state_d;
    logic          rcnt_q, rcnt_d;
    logic [63:0]   nonce_q, nonce_d;
    logic [63:0]   block_counter_q, block_counter_d;
    logic [IW-1:0] cap_cnt_q, cap_cnt_d;
    logic          flag_q, flag_d;
    entry_t        ent0_q, ent0_d, ent1_q, ent1_d, new_ent;
    logic [1:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          fall, pop, cap, full, push;

    always_comb begin
        state_d         = state_q;
        rcnt_d          = rcnt_q;
        nonce_d         = nonce_q;
        block_counter_d = block_counter_q;
        cap_cnt_d       = cap_cnt_q;
        ent0_d          = ent0_q;
        ent1_d          = ent1_q;
        overflow_d      = overflow_q;
        job_done        = 1'b0;

        xof_rst    = (state_q == XRST);
        flag_d     = xof_rst ? 1'b0 : xof_flag;
        fall       = flag_q & ~xof_flag;
        pair_valid = (count_q != 2'd0);
        pop        = pair_valid & pair_ready;
        cap        = (state_q == RUN) & fall;
        full       = (count_q == 2'd2) & ~pop;
        push       = cap & ~full;
        new_ent    = '{v1: xof_vec1, v2: xof_vec2, idx: cap_cnt_q};

        // Head is always ent0; a pop shifts ent1 forward, a push lands in the first free slot.
        if (pop) ent0_d = ent1_q;
        if (push) begin
            if (count_q == 2'd0 || (count_q == 2'd1 && pop)) ent0_d = new_ent;
            else                                             ent1_d = new_ent;
        end
        count_d = count_q + 2'(push) - 2'(pop);
        if (cap && full) overflow_d = 1'b1;

        case (state_q)
            IDLE: if (start) begin
                nonce_d         = nonce;
                block_counter_d = block_counter;
                cap_cnt_d       = '0;
                rcnt_d          = 1'b0;
                state_d         = XRST;
            end
            XRST: begin
                rcnt_d = 1'b1;
                if (rcnt_q) state_d = RUN;
            end
            RUN: if (cap) begin
                // Dropped captures still count, so an overflowed job still terminates.
                cap_cnt_d = cap_cnt_q + 1'b1;
                if (cap_cnt_q == IW'(PAIRS - 1)) state_d = DRAIN;
            end
            DRAIN: if (count_d == 2'd0) begin
                job_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            rcnt_q          <= 1'b0;
            nonce_q         <= '0;
            block_counter_q <= '0;
            cap_cnt_q       <= '0;
            flag_q          <= 1'b0;
            ent0_q          <= '0;
            ent1_q          <= '0;
            count_q         <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            rcnt_q          <= rcnt_d;
            nonce_q         <= nonce_d;
            block_counter_q <= block_counter_d;
            cap_cnt_q       <= cap_cnt_d;
            flag_q          <= flag_d;
            ent0_q          <= ent0_d;
            ent1_q          <= ent1_d;
            count_q         <= count_d;
            overflow_q      <= overflow_d;
        end
    end

    assign busy              = (state_q != IDLE);
    assign xof_run           = (state_q == RUN) && (count_q == 2'd0);
    assign xof_nonce         = nonce_q;
    assign xof_block_counter = block_counter_q;
    assign pair_vec1         = ent0_q.v1;
    assign pair_vec2         = ent0_q.v2;
    assign pair_idx          = ent0_q.idx;
    assign overflow          = overflow_q;
endmodule

// File: tb/tb_pasta_xof_sched.sv
// Directed bench for pasta_xof_sched: a simple sampler stand-in produces flag falls with known vectors.
module tb_pasta_xof_sched;
    localparam int BITLEN = 17;
    localparam int S      = 32;
    localparam int PAIRS  = 8;
    localparam int W      = BITLEN * S;

    logic          clk = 1'b0;
    logic          rst = 1'b0, start = 1'b0;
    logic [63:0]   nonce = '0, block_counter = '0;
    logic          busy, xof_rst, xof_run;
    logic [63:0]   xof_nonce, xof_block_counter;
    logic [W-1:0]  xof_vec1 = '0, xof_vec2 = '0;
    logic          xof_flag = 1'b0;
    logic          pair_valid;
    logic          pair_ready = 1'b0;
    logic [W-1:0]  pair_vec1, pair_vec2;
    logic [2:0]    pair_idx;
    logic          job_done, overflow;
    int            total = 0, bad = 0;

    pasta_xof_sched #(.BITLEN(BITLEN), .S(S), .PAIRS(PAIRS)) dut (
        .clk(clk), .rst(rst), .start(start), .nonce(nonce), .block_counter(block_counter),
        .busy(busy), .xof_rst(xof_rst), .xof_run(xof_run), .xof_nonce(xof_nonce),
        .xof_block_counter(xof_block_counter), .xof_vec1(xof_vec1), .xof_vec2(xof_vec2),
        .xof_flag(xof_flag), .pair_valid(pair_valid), .pair_ready(pair_ready),
        .pair_vec1(pair_vec1), .pair_vec2(pair_vec2), .pair_idx(pair_idx),
        .job_done(job_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] v1f(input int i);
        return {(W/32){32'hA500_0000 | 32'(i)}};
    endfunction
    function automatic logic [W-1:0] v2f(input int i);
        return {(W/32){32'h5A00_0100 + 32'(i * 3)}};
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; xof_flag = 1'b0; pair_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Start a job and walk through the two xof_rst cycles into RUN.
    task automatic start_job(input logic [63:0] n, input logic [63:0] b);
        @(posedge clk); #1;
        start = 1'b1; nonce = n; block_counter = b;
        @(posedge clk); #1;
        start = 1'b0; nonce = '1; block_counter = '1;
        @(negedge clk);
        total++; if (xof_rst !== 1'b1 || busy !== 1'b1 || xof_run !== 1'b0) begin bad++;
            $display("FAIL start_c1 xof_rst=%b busy=%b xof_run=%b want 1 1 0", xof_rst, busy, xof_run); end
        @(negedge clk);
        total++; if (xof_rst !== 1'b1 || xof_run !== 1'b0) begin bad++;
            $display("FAIL start_c2 xof_rst=%b xof_run=%b want 1 0", xof_rst, xof_run); end
        @(negedge clk);
        total++; if (xof_rst !== 1'b0 || xof_run !== 1'b1 || busy !== 1'b1) begin bad++;
            $display("FAIL start_c3 xof_rst=%b xof_run=%b busy=%b want 0 1 1", xof_rst, xof_run, busy); end
        total++; if (xof_nonce !== n || xof_block_counter !== b) begin bad++;
            $display("FAIL latch nonce=%h bc=%h want %h %h", xof_nonce, xof_block_counter, n, b); end
    endtask

    // Raise then drop xof_flag; returns #1 into the cycle where the fall is visible.
    task automatic gen_fall(input int i, input bit honour_run);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (honour_run && !xof_run && n < 50) begin @(posedge clk); #1; n++; end
        if (honour_run && !xof_run) begin total++; bad++;
            $display("FAIL run_wait xof_run=%b after %0d cycles, want 1", xof_run, n); end
        xof_flag = 1'b1;
        @(posedge clk); #1;
        xof_flag = 1'b0; xof_vec1 = v1f(i); xof_vec2 = v2f(i);
    endtask

    // Produce pairs lo..hi-1 with the consumer always ready.
    task automatic run_pairs(input int lo, input int hi);
        pair_ready = 1'b1;
        for (int i = lo; i < hi; i++) begin
            gen_fall(i, 1'b1);
            @(negedge clk);
            total++; if (pair_valid !== 1'b0) begin bad++;
                $display("FAIL early_valid idx=%0d pair_valid=%b want 0", i, pair_valid); end
            @(posedge clk); #1;
            xof_vec1 = ~v1f(i); xof_vec2 = ~v2f(i);
            @(negedge clk);
            total++; if (pair_valid !== 1'b1 || pair_idx !== 3'(i)) begin bad++;
                $display("FAIL stream_head valid=%b idx=%0d want 1 %0d", pair_valid, pair_idx, i); end
            total++; if (pair_vec1 !== v1f(i) || pair_vec2 !== v2f(i)) begin bad++;
                $display("FAIL stream_data idx=%0d vec1[31:0]=%h vec2[31:0]=%h want %h %h",
                         i, pair_vec1[31:0], pair_vec2[31:0], v1f(i) & 544'hFFFF_FFFF, v2f(i) & 544'hFFFF_FFFF); end
            total++; if (job_done !== (i == PAIRS - 1)) begin bad++;
                $display("FAIL job_done idx=%0d job_done=%b want %b", i, job_done, i == PAIRS - 1); end
        end
        if (hi == PAIRS) begin
            @(negedge clk);
            total++; if (busy !== 1'b0 || job_done !== 1'b0 || pair_valid !== 1'b0) begin bad++;
                $display("FAIL job_end busy=%b job_done=%b valid=%b want 0 0 0", busy, job_done, pair_valid); end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        total++; if ({xof_rst, xof_run, busy, pair_valid, job_done, overflow} !== 6'b0) begin bad++;
            $display("FAIL reset_ctrl got=%b want 000000", {xof_rst, xof_run, busy, pair_valid, job_done, overflow}); end
        total++; if (pair_vec1 !== '0 || pair_vec2 !== '0 || pair_idx !== 3'd0) begin bad++;
            $display("FAIL reset_data idx=%0d vec1_nz=%b vec2_nz=%b want 0", pair_idx, |pair_vec1, |pair_vec2); end
        total++; if (xof_nonce !== 64'd0 || xof_block_counter !== 64'd0) begin bad++;
            $display("FAIL reset_latch nonce=%h bc=%h want 0 0", xof_nonce, xof_block_counter); end
        start_job(64'h1, 64'h0);
    endtask

    task automatic test_stream();
        run_pairs(0, PAIRS);
        total++; if (overflow !== 1'b0) begin bad++;
            $display("FAIL stream_ovf overflow=%b want 0", overflow); end
    endtask

    task automatic test_backpressure();
        start_job(64'hDEAD_BEEF_0000_0001, 64'h2);
        pair_ready = 1'b0;
        gen_fall(0, 1'b1);
        @(posedge clk); @(negedge clk);
        total++; if (pair_valid !== 1'b1 || pair_idx !== 3'd0 || xof_run !== 1'b0) begin bad++;
            $display("FAIL bp_first valid=%b idx=%0d run=%b want 1 0 0", pair_valid, pair_idx, xof_run); end
        gen_fall(1, 1'b0);
        @(posedge clk); @(negedge clk);
        total++; if (overflow !== 1'b0 || pair_idx !== 3'd0 || xof_run !== 1'b0) begin bad++;
            $display("FAIL bp_full ovf=%b idx=%0d run=%b want 0 0 0", overflow, pair_idx, xof_run); end
        pair_ready = 1'b1;
        @(negedge clk);
        total++; if (pair_valid !== 1'b1 || pair_idx !== 3'd1 || pair_vec1 !== v1f(1) || xof_run !== 1'b0) begin bad++;
            $display("FAIL bp_pop0 valid=%b idx=%0d run=%b want 1 1 0", pair_valid, pair_idx, xof_run); end
        @(negedge clk);
        total++; if (pair_valid !== 1'b0 || xof_run !== 1'b1) begin bad++;
            $display("FAIL bp_pop1 valid=%b run=%b want 0 1", pair_valid, xof_run); end
        run_pairs(2, PAIRS);
    endtask

    task automatic test_overflow();
        start_job(64'h7, 64'h3);
        pair_ready = 1'b0;
        gen_fall(0, 1'b1);
        @(posedge clk);
        gen_fall(1, 1'b0);
        @(posedge clk);
        gen_fall(2, 1'b0);
        @(posedge clk); @(negedge clk);
        total++; if (overflow !== 1'b1 || pair_idx !== 3'd0 || pair_vec1 !== v1f(0)) begin bad++;
            $display("FAIL ovf_set ovf=%b idx=%0d want 1 0", overflow, pair_idx); end
        pair_ready = 1'b1;
        @(negedge clk);
        total++; if (pair_valid !== 1'b1 || pair_idx !== 3'd1 || pair_vec2 !== v2f(1)) begin bad++;
            $display("FAIL ovf_second valid=%b idx=%0d want 1 1", pair_valid, pair_idx); end
        @(negedge clk);
        total++; if (pair_valid !== 1'b0) begin bad++;
            $display("FAIL ovf_dropped valid=%b idx=%0d want valid 0", pair_valid, pair_idx); end
        run_pairs(3, PAIRS);
        total++; if (overflow !== 1'b1) begin bad++;
            $display("FAIL ovf_sticky overflow=%b want 1", overflow); end
    endtask

    task automatic test_push_pop();
        apply_reset();
        @(negedge clk);
        total++; if (overflow !== 1'b0) begin bad++;
            $display("FAIL ovf_clear overflow=%b want 0", overflow); end
        start_job(64'h9, 64'h4);
        pair_ready = 1'b0;
        gen_fall(0, 1'b1);
        @(posedge clk);
        gen_fall(1, 1'b0);
        pair_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if (pair_valid !== 1'b1 || pair_idx !== 3'd1 || pair_vec1 !== v1f(1) || overflow !== 1'b0) begin bad++;
            $display("FAIL pp_head valid=%b idx=%0d ovf=%b want 1 1 0", pair_valid, pair_idx, overflow); end
        @(negedge clk);
        total++; if (pair_valid !== 1'b0 || xof_run !== 1'b1) begin bad++;
            $display("FAIL pp_count valid=%b run=%b want 0 1", pair_valid, xof_run); end
    endtask

    task automatic test_midjob_reset();
        apply_reset();
        start_job(64'h2, 64'h0);
        run_pairs(0, 3);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++; if (pair_valid !== 1'b0 || busy !== 1'b0 || pair_idx !== 3'd0 || xof_block_counter !== 64'd0) begin bad++;
            $display("FAIL mid_rst valid=%b busy=%b idx=%0d bc=%h want 0 0 0 0", pair_valid, busy, pair_idx, xof_block_counter); end
        start_job(64'h3, 64'h5);
        run_pairs(0, PAIRS);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_overflow();
        test_push_pop();
        test_midjob_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pasta_xof_sched.md
# pasta_xof_sched

Sequencer and output buffer for the SHAKE128 rejection-sampling XOF in the Pasta datapath. On a start request it resets and runs the XOF for one keystream block (nonce plus block counter). It collects a fixed number of completed (vec1, vec2) sample-vector pairs and hands them to the affine-layer consumer over a valid/ready handshake. It throttles the XOF whenever the consumer applies backpressure.

## Interface
Parameters:
- BITLEN, 17, bits per sample (mod q = 65537)
- S, 32, samples per vector
- PAIRS, 8, vector pairs produced per job

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request pulse; sampled only in IDLE
- nonce  in  64  latched on accepted start
- block_counter  in  64  latched on accepted start
- busy  out  1  high in every state except IDLE
- xof_rst  out  1  drives the sampler's reset
- xof_run  out  1  drives the sampler's rounds_done; low stalls squeezing
- xof_nonce  out  64  latched nonce to the sampler
- xof_block_counter  out  64  latched counter to the sampler
- xof_vec1, xof_vec2  in  BITLEN*S  sampler vector buffers
- xof_flag  in  1  sampler buffer-select flag; a 1→0 transition marks a completed pair
- pair_valid  out  1  head pair available
- pair_ready  in  1  consumer accepts head pair
- pair_vec1, pair_vec2  out  BITLEN*S  head pair data
- pair_idx  out  $clog2(PAIRS)  index of head pair within the job
- job_done  out  1  one-cycle pulse at job end
- overflow  out  1  sticky error flag; cleared only by rst

## Operation
- States: IDLE, XRST, RUN, DRAIN.
- IDLE
  - start=1: latch nonce and block_counter, clear capture counter cap_cnt, go to XRST.
- XRST
  - xof_rst=1 for exactly 2 cycles, then go to RUN.
- RUN
  - Register the flag each cycle as flag_q.
  - fall = flag_q & ~xof_flag. flag_q is forced to 0 while xof_rst=1.
  - On fall, push {xof_vec1, xof_vec2, cap_cnt} into a 2-entry FIFO and increment cap_cnt.
  - After pushing pair PAIRS-1, go to DRAIN.
- xof_run = (state==RUN) & (fifo_count==0).
  - The sampler completes at most one further pair after xof_run falls. The second FIFO entry absorbs that pair.
- A fall with the FIFO full (count 2, no pop in the same cycle): the data is dropped, overflow is set, and cap_cnt still increments.
- A fall while in DRAIN or IDLE is ignored.
- DRAIN
  - xof_run=0.
  - When the FIFO becomes empty, pulse job_done and go to IDLE.
- FIFO
  - Head drives pair_vec1, pair_vec2 and pair_idx.
  - pair_valid = (count != 0).
  - Pop on pair_valid & pair_ready.
  - A push and a pop in the same cycle leave count unchanged, and order is preserved.
- start outside IDLE is ignored. The latched nonce and block_counter are held until the next accepted start.
- rst in any state returns to IDLE. FIFO, counters, flag_q and overflow are all cleared. There is no partial-job completion.

## Timing
- Reset values:
  - xof_rst=0, xof_run=0, busy=0, pair_valid=0, job_done=0, overflow=0.
  - pair_vec1, pair_vec2, pair_idx, xof_nonce and xof_block_counter are all 0.
- start accepted at edge T:
  - xof_rst high during cycles T+1 and T+2.
  - xof_run high from T+3, since the FIFO is empty.
- A 1→0 transition on xof_flag at edge E:
  - fall is seen in the cycle after E, and the push happens at edge E+1.
  - pair_valid is high from E+1 if the FIFO was empty.
- Pop latency: the next entry is presented the cycle after a pop.
- The FIFO capture at E+1 uses the sampler values registered at E. This is valid even if the sampler shifts a new sample into xof_vec1 at E+1.
- job_done is asserted in the cycle the last entry pops, coincident with the DRAIN→IDLE transition. A start in the cycle after job_done is accepted.

## Test plan
- Reset/idle
  - Stimulus: rst high 3 cycles, then low.
  - Required: all outputs 0. start=1 with nonce=0x1, block_counter=0x0 gives xof_rst high for exactly 2 cycles, then xof_run=1, busy=1.
- Streaming, always ready
  - Stimulus: behavioural sampler model with xof_flag toggling, pair_ready=1.
  - Required: 8 pairs, pair_idx 0..7, each matching the sampler buffers at the 1→0 edge. Each pair_valid follows its fall by 1 cycle. job_done pulses once. overflow=0.
- Backpressure
  - Stimulus: pair_ready=0 until 2 pairs are captured.
  - Required: xof_run drops after the first push. FIFO count reaches 2 with no overflow. Releasing ready pops idx 0 then 1, and xof_run reasserts.
- Overflow
  - Stimulus: the model ignores xof_run and produces a third pair while the FIFO is full.
  - Required: overflow=1 sticky, the third pair is dropped, and job_done still pulses after 8 captures are counted.
- Simultaneous push/pop
  - Stimulus: a fall in the same cycle as a pop with count 1.
  - Required: count stays 1, and the next head has the correct idx.
- Mid-job reset and restart
  - Stimulus: rst asserted in RUN after 3 pairs, then start with block_counter=0x5.
  - Required: FIFO empty, pair_idx restarts at 0, and xof_block_counter=0x5.
